// File: rtl/bcd_formatter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_formatter_seq
//  Description : Multi-channel sequential binary-to-BCD formatter. All
//                channels run shift-add-3 in parallel, one bit per clock,
//                with valid/ready handshakes on input and output. Channels
//                whose value does not fit in DIGITS digits saturate to 9s.
//                Optional macro LZ_BLANK_EN replaces leading-zero digits
//                with the blank code 4'hF.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_formatter_seq #(
    parameter int CHANNELS = 3,
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BIN_W-1:0]    bin_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
    output logic [CHANNELS-1:0]          ovf
);

    localparam int c_dw    = DIGITS * 4;
    localparam int c_bcd_w = CHANNELS * c_dw;
    localparam int c_bin_w = CHANNELS * BIN_W;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);

    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_bin_w-1:0]  r_bin;
    logic [c_bcd_w-1:0]  r_bcd;
    logic [CHANNELS-1:0] r_ovf;
    logic                r_valid;
    logic [c_bcd_w-1:0]  r_bcd_out;
    logic [CHANNELS-1:0] r_ovf_out;

    logic [c_bcd_w-1:0]  w_bcd_nxt;
    logic [c_bin_w-1:0]  w_bin_nxt;
    logic [CHANNELS-1:0] w_ovf_nxt;
    logic [c_dw-1:0]     w_adj;
    logic [3:0]          w_dig;
    logic [c_bcd_w-1:0]  w_fmt;
    logic [3:0]          w_fdig;
`ifdef LZ_BLANK_EN
    logic                w_lead;
`endif

    // One double-dabble step per channel: add 3 to digits >= 5, then shift
    // {bcd,bin} left; the bit leaving the top digit flags overflow (sticky).
    always_comb begin
        w_bcd_nxt = '0;
        w_bin_nxt = '0;
        w_ovf_nxt = '0;
        w_adj     = '0;
        w_dig     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int d = 0; d < DIGITS; d++) begin
                w_dig = r_bcd[k*c_dw + d*4 +: 4];
                w_adj[d*4 +: 4] = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
            end
            w_ovf_nxt[k]                = r_ovf[k] | w_adj[c_dw-1];
            w_bcd_nxt[k*c_dw +: c_dw]   = {w_adj[c_dw-2:0], r_bin[k*BIN_W + BIN_W - 1]};
            w_bin_nxt[k*BIN_W +: BIN_W] = r_bin[k*BIN_W +: BIN_W] << 1;
        end
    end

    // Final digit formatting: saturate overflowed channels, optionally blank
    // leading zeros (digit 0 always shown, saturated channels never blanked).
    always_comb begin
        w_fmt  = '0;
        w_fdig = '0;
`ifdef LZ_BLANK_EN
        w_lead = 1'b1;
`endif
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef LZ_BLANK_EN
            w_lead = 1'b1;
`endif
            for (int d = DIGITS - 1; d >= 0; d--) begin
                w_fdig = r_bcd[k*c_dw + d*4 +: 4];
                if (r_ovf[k]) begin
                    w_fmt[k*c_dw + d*4 +: 4] = 4'h9;
                end
`ifdef LZ_BLANK_EN
                else if ((d != 0) && w_lead && (w_fdig == 4'h0)) begin
                    w_fmt[k*c_dw + d*4 +: 4] = 4'hF;
                end
`endif
                else begin
                    w_fmt[k*c_dw + d*4 +: 4] = w_fdig;
                end
`ifdef LZ_BLANK_EN
                w_lead = w_lead & (w_fdig == 4'h0);
`endif
            end
        end
    end

    // Control FSM, conversion registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf     <= '0;
            r_valid   <= 1'b0;
            r_bcd_out <= '0;
            r_ovf_out <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_ovf   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    r_bin <= w_bin_nxt;
                    r_bcd <= w_bcd_nxt;
                    r_ovf <= w_ovf_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    // First DONE cycle captures the formatted result; it is
                    // then held until the consumer takes it.
                    if (!r_valid) begin
                        r_bcd_out <= w_fmt;
                        r_ovf_out <= r_ovf;
                        r_valid   <= 1'b1;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = r_valid;
    assign bcd_out   = r_bcd_out;
    assign ovf       = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_bcd_formatter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_formatter_seq
//  Description : Self-checking bench for bcd_formatter_seq (default params),
//                directed cases plus random values against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_formatter_seq;

    localparam int CH = 3;
    localparam int BW = 6;
    localparam int DG = 2;
    localparam int LAT = BW + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*BW-1:0]     bin_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DG*4-1:0]   bcd_out;
    logic [CH-1:0]        ovf;

    int checks = 0;
    int errors = 0;

    bcd_formatter_seq #(.CHANNELS(CH), .BIN_W(BW), .DIGITS(DG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digits by division, saturation by magnitude test.
    function automatic void model(input logic [CH*BW-1:0] v,
                                  output logic [CH*DG*4-1:0] b,
                                  output logic [CH-1:0] o);
        int val;
        int p10 [DG+1];
        p10[0] = 1;
        for (int i = 1; i <= DG; i++) p10[i] = p10[i-1] * 10;
        b = '0;
        o = '0;
        for (int k = 0; k < CH; k++) begin
            val = int'(v[k*BW +: BW]);
            if (val >= p10[DG]) begin
                o[k] = 1'b1;
                for (int d = 0; d < DG; d++) b[k*DG*4 + d*4 +: 4] = 4'h9;
            end else begin
                for (int d = 0; d < DG; d++) begin
                    b[k*DG*4 + d*4 +: 4] = 4'((val / p10[d]) % 10);
`ifdef LZ_BLANK_EN
                    if (d > 0 && val < p10[d]) b[k*DG*4 + d*4 +: 4] = 4'hF;
`endif
                end
            end
        end
    endfunction

    function automatic logic [CH*BW-1:0] pack3(input int c2, input int c1, input int c0);
        return {BW'(c2), BW'(c1), BW'(c0)};
    endfunction

    // Present a transaction and let it be accepted on the next rising edge.
    task automatic send(input logic [CH*BW-1:0] v);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = (CH*BW)'($urandom);
    endtask

    // Wait (bounded) for out_valid, then check latency and result.
    task automatic collect(input logic [CH*BW-1:0] v);
        logic [CH*DG*4-1:0] eb;
        logic [CH-1:0]      eo;
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        model(v, eb, eo);
        chk("latency", 64'(lat), 64'(LAT));
        chk("bcd_out", 64'(bcd_out), 64'(eb));
        chk("ovf", 64'(ovf), 64'(eo));
    endtask

    // Full transaction with out_ready high; checks return to IDLE afterwards.
    task automatic txn(input logic [CH*BW-1:0] v);
        out_ready = 1'b1;
        send(v);
        collect(v);
        @(posedge clk); #1;
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [CH*BW-1:0]   va;
        logic [CH*BW-1:0]   vb;
        logic [CH*DG*4-1:0] eb;
        logic [CH-1:0]      eo;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_bcd_out", 64'(bcd_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clock example hr=23, min=7, sec=59.
        txn(pack3(23, 7, 59));
`ifndef LZ_BLANK_EN
        chk("clock_example", 64'(bcd_out), 64'h230759);
`endif
        // Boundaries: max, zero, two-digit limits, leading-zero cases.
        txn(pack3(63, 63, 63));
        txn(pack3(0, 10, 63));
        txn(pack3(0, 7, 42));
        txn(pack3(9, 1, 0));

        // Backpressure: result held, new input ignored until released.
        va = pack3(45, 8, 31);
        vb = pack3(12, 60, 3);
        out_ready = 1'b0;
        send(va);
        collect(va);
        model(va, eb, eo);
        in_valid = 1'b1;
        bin_in   = vb;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_bcd_stable", 64'(bcd_out), 64'(eb));
            chk("bp_ovf_stable", 64'(ovf), 64'(eo));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("bp_next_accept", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        collect(vb);
        @(posedge clk); #1;

        // Reset during SHIFT cycle 3 discards the partial conversion.
        out_ready = 1'b1;
        send(pack3(50, 50, 50));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_bcd_out", 64'(bcd_out), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(pack3(38, 0, 19));

        // Random values across the full input range.
        for (int n = 0; n < 40; n++) begin
            txn((CH*BW)'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
